if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined RV32I core. Holds the program counter and drives the fetch address into the asynchronous-read instruction memory. Captures the returned word into the IF/ID pipeline register. Handles hazard-unit stalls, EX-stage control-flow redirects (flush), out-of-range fetch faults and a sticky halt, and keeps a retired-fetch counter for the benches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_DEPTH, 1024, instruction memory depth in 32-bit words; legal fetch range is 0 to MEM_DEPTH*4-1
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID
redirect_valid  input  1  EX stage: taken branch/jump, fetch from redirect_target
redirect_target  input  32  new fetch address; bits [1:0] ignored
halt_req  input  1  ecall/halt reached downstream; freeze fetch
imem_addr  output  32  byte address to instruction memory (combinational = pc)
imem_dout  input  32  instruction word from memory (same-cycle, asynchronous)
ifid_pc  output  32  PC of instruction held in IF/ID
ifid_pc_plus4  output  32  ifid_pc + 4
ifid_inst  output  32  instruction held in IF/ID
ifid_valid  output  1  IF/ID holds a real instruction
fetch_fault  output  1  sticky: fetch attempted outside memory range
halted  output  1  sticky halt state
fetch_count  output  32  number of valid instructions latched into IF/ID

Behaviour:
- Reset is synchronous, active-high. On a reset edge: pc=RESET_PC, ifid_pc=0, ifid_pc_plus4=4, ifid_inst=NOP_INST, ifid_valid=0, fetch_fault=0, halted=0, fetch_count=0. Memory content is not valid during reset cycles, so nothing is latched from imem_dout.
- imem_addr = pc, combinational. There is no internal read latency: the word read from imem_dout in cycle N is the one latched at the end of cycle N. Fetch-to-IF/ID latency is 1 clock.
- Per-edge priority (highest first): reset > halted/halt_req > redirect_valid > stall > range fault > normal.
- Halt: halt_req sets halted at the next edge. While halted: pc holds, ifid_valid=0, ifid_inst=NOP_INST, and fetch_count holds. Only reset clears halted. A redirect that coincides with halt_req is dropped.
- Redirect: pc <= {redirect_target[31:2],2'b00}. The IF/ID register becomes a bubble (valid=0, inst=NOP_INST). fetch_fault is cleared. Redirect overrides a simultaneous stall.
- Stall (no redirect/halt): pc, IF/ID, fetch_count and fetch_fault all hold.
- Range fault: if pc >= MEM_DEPTH*4, then pc holds, fetch_fault <= 1 and the IF/ID register becomes a bubble. The fault clears only on redirect or reset.
- Normal: ifid_inst <= imem_dout; ifid_pc <= pc; ifid_pc_plus4 <= pc+4; ifid_valid <= 1; pc <= pc+4; fetch_count <= fetch_count+1.
- Arithmetic: all adds are 32-bit modulo. pc+4 wraps at 2^32, and fetch_count wraps. An address that wraps becomes range-checked as usual.
- States: RUN (normal/stall/redirect), FAULT (fetch_fault=1, IF/ID bubbles; exits to RUN on redirect), HALT (terminal until reset).
  - RUN->FAULT on an out-of-range pc.
  - RUN/FAULT->HALT on halt_req.
  - any->reset on reset.
- Reset mid-operation: all state returns to reset values at that edge, regardless of stall, redirect or halt.

Test Plan:
- Reset 2 cycles, memory holding 0x00500093, 0x00A00113, 0x002081B3 at 0x0/0x4/0x8 -> IF/ID shows (pc 0x0, valid 1), then 0x4, then 0x8 on consecutive edges; fetch_count=3; ifid_valid=0 during reset.
- stall high for 3 cycles after first fetch -> imem_addr stays 0x4; ifid_pc stays 0x0; fetch_count stays 1; fetch resumes at 0x4 on release.
- redirect_valid with target 0x22 while stall high -> pc=0x20 next cycle, IF/ID bubble (valid 0, inst 0x00000013), then 0x20 is latched on the following edge.
- Run sequentially to pc=0xFFC with MEM_DEPTH=1024 -> 0xFFC latched valid; next cycle fetch_fault=1, pc holds 0x1000, bubbles; redirect to 0x0 clears the fault and fetch restarts.
- halt_req pulse for 1 cycle plus a simultaneous redirect -> halted=1, pc frozen, ifid_valid=0 indefinitely, redirect ignored; reset -> pc=0x0, halted=0.
- Assert reset mid-run at pc=0x40 with stall high -> next edge pc=0x0, ifid_valid=0, fetch_count=0, fetch_fault=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the asynchronous instruction memory
// and fills the IF/ID pipeline register, with stall, redirect, range-fault and halt handling.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] FETCH_LIMIT = 32'(MEM_DEPTH * 4);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FAULT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        out_of_range;

  // Targets are always word aligned; the low bits are discarded on redirect.
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];

  assign imem_addr    = pc;
  assign pc_plus4     = pc + 32'd4;
  assign out_of_range = (pc >= FETCH_LIMIT);

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values of pc and state, exactly like independent flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc            <= RESET_PC;
      ifid_pc       <= 32'h0000_0000;
      ifid_pc_plus4 <= 32'h0000_0004;
      ifid_inst     <= NOP_INST;
      ifid_valid    <= 1'b0;
      fetch_fault   <= 1'b0;
      halted        <= 1'b0;
      fetch_count   <= 32'h0000_0000;
    end else if (state == HALT || halt_req) begin
      // Terminal until reset; a redirect arriving with the halt is dropped.
      state      <= HALT;
      halted     <= 1'b1;
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
    end else if (redirect_valid) begin
      state       <= RUN;
      pc          <= {redirect_target[31:2], 2'b00};
      ifid_inst   <= NOP_INST;
      ifid_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (stall) begin
      state <= state;
    end else if (out_of_range) begin
      state       <= FAULT;
      fetch_fault <= 1'b1;
      ifid_inst   <= NOP_INST;
      ifid_valid  <= 1'b0;
    end else begin
      state         <= RUN;
      pc            <= pc_plus4;
      ifid_pc       <= pc;
      ifid_pc_plus4 <= pc_plus4;
      ifid_inst     <= imem_dout;
      ifid_valid    <= 1'b1;
      fetch_count   <= fetch_count + 32'd1;
    end
  end

endmodule
